// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone classic arbiter sharing one single-port synchronous RAM.
// Every access is a fixed IDLE -> ISSUE -> ACK sequence; m0 = fetch, m1 = data.
module wb_ram_arbiter #(
   parameter int unsigned ADR_W = 12,
   parameter bit          RR_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [3:0]       m0_sel_i,
   input  logic [31:0]      m0_dat_i,
   output logic [31:0]      m0_dat_o,
   output logic             m0_ack_o,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [3:0]       m1_sel_i,
   input  logic [31:0]      m1_dat_i,
   output logic [31:0]      m1_dat_o,
   output logic             m1_ack_o,
   output logic             ram_we_o,
   output logic [ADR_W-1:0] ram_adr_o,
   output logic [3:0]       ram_be_o,
   output logic [31:0]      ram_dat_o,
   input  logic [31:0]      ram_dat_i,
   output logic [1:0]       gnt_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             last_gnt_q, last_gnt_d;   // 1 = m1 was granted last
   logic [ADR_W-1:0] adr_q, adr_d;

   logic             req0, req1;
   logic             g_cyc, g_stb, g_we;
   logic [ADR_W-1:0] g_adr;
   logic [3:0]       g_sel;
   logic [31:0]      g_dat;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   // Route the currently granted master's bus signals
   always_comb begin
      if (gnt_q[1]) begin
         g_cyc = m1_cyc_i;
         g_stb = m1_stb_i;
         g_we  = m1_we_i;
         g_adr = m1_adr_i;
         g_sel = m1_sel_i;
         g_dat = m1_dat_i;
      end else begin
         g_cyc = m0_cyc_i;
         g_stb = m0_stb_i;
         g_we  = m0_we_i;
         g_adr = m0_adr_i;
         g_sel = m0_sel_i;
         g_dat = m0_dat_i;
      end
   end

   // Next-state, grant selection and round-robin history
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = ISSUE;
               if (req0 && req1)
                  gnt_d = (RR_EN && last_gnt_q) ? 2'b01 : 2'b10;
               else
                  gnt_d = req1 ? 2'b10 : 2'b01;
            end
         end
         ISSUE: state_d = ACK;
         ACK: begin
            state_d    = IDLE;
            last_gnt_d = gnt_q[1];
            gnt_d      = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // RAM strobes during ISSUE, acknowledges during ACK; address held otherwise
   always_comb begin
      ram_we_o  = 1'b0;
      ram_be_o  = '0;
      ram_dat_o = '0;
      ram_adr_o = adr_q;
      adr_d     = adr_q;
      m0_ack_o  = 1'b0;
      m1_ack_o  = 1'b0;
      case (state_q)
         ISSUE: begin
            ram_adr_o = g_adr;
            adr_d     = g_adr;
            ram_be_o  = g_sel;
            ram_dat_o = g_dat;
            ram_we_o  = g_we & g_cyc & g_stb;
         end
         ACK: begin
            m0_ack_o = gnt_q[0] & req0;
            m1_ack_o = gnt_q[1] & req1;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = ram_dat_i;
   assign m1_dat_o = ram_dat_i;
   assign gnt_o    = gnt_q;
   assign busy_o   = (state_q != IDLE);

   // State, grant, history and held-address registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_gnt_q <= 1'b1;
         adr_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         adr_q      <= adr_d;
      end
   end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Two-port Wishbone classic slave arbiter that shares the single-port on-chip RAM (synchronous read, 1-cycle latency, byte enables) between the instruction-fetch master (m0) and the data master (m1). It sequences every access as a fixed 2-cycle transaction: issue, then acknowledge. It sits between the CPU bus interfaces and the RAM macro.

Parameters:
ADR_W, 12, word-address width; matches RAM depth of 4096 words
RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority, m1 (data) always wins

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
m0_cyc_i / m1_cyc_i  in  1  bus cycle valid, per master
m0_stb_i / m1_stb_i  in  1  strobe, per master
m0_we_i / m1_we_i  in  1  1 = write, per master
m0_adr_i / m1_adr_i  in  ADR_W  word address, per master
m0_sel_i / m1_sel_i  in  4  byte selects, per master
m0_dat_i / m1_dat_i  in  32  write data, per master
m0_dat_o / m1_dat_o  out  32  read data, per master
m0_ack_o / m1_ack_o  out  1  transfer acknowledge, per master
ram_we_o  out  1  RAM write enable
ram_adr_o  out  ADR_W  RAM word address
ram_be_o  out  4  RAM byte enables
ram_dat_o  out  32  RAM write data
ram_dat_i  in  32  RAM registered read data
gnt_o  out  2  one-hot current grant; 00 when idle
busy_o  out  1  1 while in ISSUE or ACK

Behaviour:
- Request: reqN = mN_cyc_i & mN_stb_i.
- FSM states: IDLE, ISSUE, ACK. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: register the grant, go to ISSUE.
  - Both requesting with RR_EN=1: grant the master not granted last. last_gnt resets to m1, so m0 wins the first tie.
  - Both requesting with RR_EN=0: grant m1.
- ISSUE:
  - ram_adr_o, ram_be_o, ram_dat_o and ram_we_o are driven combinationally from the granted master.
  - ram_we_o = granted we & granted cyc & stb.
  - RAM samples on the closing edge. Always go to ACK.
- ACK:
  - Granted mN_ack_o = 1 for exactly this cycle, gated by that master's cyc & stb. If the master aborted, no ack is given, but the write has already committed.
  - mN_dat_o = ram_dat_i for the granted master.
  - Update last_gnt. Go to IDLE. No back-to-back issue, so the master must drop or re-present stb after ack.
- Outside ISSUE, ram_we_o = 0 and ram_be_o = 0. ram_adr_o holds its last value; it is don't-care but must be stable.
- Non-granted master: ack = 0. The dat_o of either master outside its ACK is don't-care, but driven from ram_dat_i.
- Latency: request seen in IDLE at cycle n, ack at cycle n+2. Peak throughput is one transfer per 3 cycles.
- A write acked in ACK returns the old RAM word on dat_o; the RAM is read-before-write. Masters ignore dat_o on writes.
- Sub-word writes: only bytes with sel=1 change.
- Async reset mid-transaction: state → IDLE, gnt_o = 0, busy_o = 0, all acks = 0, ram_we_o = 0, ram_be_o = 0, last_gnt = m1.
- Reset values of all outputs: 0, except dat_o, which follows ram_dat_i.
- No combinational path from ram_dat_i to any ack.

Test Plan:
- m0 reads adr 0x000 (RAM preloaded 0x2401000c), sel=F → m0_ack_o high exactly 2 cycles after request, m0_dat_o = 0x2401000c, gnt_o = 01 during ISSUE/ACK.
- m1 writes 0xDEADBEEF to adr 0x100 with sel=0101, then reads it back (old word 0) → readback 0x00AD00EF; m0_ack_o never asserted.
- Both request continuously, RR_EN=1, 6 transfers → grants alternate m0, m1, m0, m1, m0, m1; each ack one cycle wide, 3-cycle spacing.
- Same stimulus with RR_EN=0 → m1 granted every transfer; m0 starves while m1 requests.
- m1 write issued, m1_cyc_i dropped during ACK → no m1_ack_o, RAM word updated; FSM back in IDLE next cycle.
- rst_n_i pulsed low during ISSUE of an m0 write → all outputs 0 immediately (asynchronously); after release, m0 wins the first tie with m1.
